// File: rtl/drac_pkg.sv
// Shared front-end types: fetch-to-decode packet and fetch queue sizing.
package drac_pkg;

  localparam int FETCH_QUEUE_DEPTH = 4;

  typedef logic [$clog2(FETCH_QUEUE_DEPTH):0] fq_ptr_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] origin;
  } exception_t;

  typedef struct packed {
    logic        is_branch;
    logic        decision;
    logic [31:0] pred_addr;
  } bpred_t;

  typedef struct packed {
    logic [31:0] pc_inst;
    logic [31:0] inst;
    logic        valid;
    exception_t  ex;
    bpred_t      bpred;
  } if_id_stage_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch->decode packet queue with flush.
// FETCH_QUEUE_BYPASS_EN enables a 0-cycle path from fetch to decode when empty.
module fetch_queue
  import drac_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  if_id_stage_t               fetch_i,
  output logic                       ready_o,
  input  logic                       decode_ready_i,
  output if_id_stage_t               fetch_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int IDX = $clog2(DEPTH);
  localparam int PW  = IDX + 1;

  if_id_stage_t mem [DEPTH];

  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW-1:0]  count_q;
  logic [IDX-1:0] wr_idx;
  logic [IDX-1:0] rd_idx;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           push_wr;
  logic           pop_rd;
  if_id_stage_t   head;

  assign wr_idx = wr_ptr_q[IDX-1:0];
  assign rd_idx = rd_ptr_q[IDX-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX] != rd_ptr_q[IDX]);

  assign ready_o = !full;
  assign count_o = count_q;
  assign head    = empty ? '0 : mem[rd_idx];

  assign push = fetch_i.valid & ready_o & !flush_i;
  assign pop  = fetch_o.valid & decode_ready_i & !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = empty & fetch_i.valid & !flush_i;

  // A bypassed packet that decode takes immediately never touches storage.
  assign push_wr = push & !(bypass & decode_ready_i);
  assign pop_rd  = pop & !bypass;

  always_comb begin
    fetch_o = bypass ? fetch_i : head;
    if (flush_i) fetch_o.valid = 1'b0;
  end
`else
  assign push_wr = push;
  assign pop_rd  = pop;

  always_comb begin
    fetch_o = head;
    if (flush_i) fetch_o.valid = 1'b0;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (push_wr) mem[wr_idx] <= fetch_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_rd)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_wr && !pop_rd)      count_q <= count_q + PW'(1);
      else if (pop_rd && !push_wr) count_q <= count_q - PW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue (default build, DEPTH = 4).
module tb_fetch_queue;
  import drac_pkg::*;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         flush_i = 1'b0;
  if_id_stage_t fetch_i = '0;
  logic         ready_o;
  logic         decode_ready_i = 1'b0;
  if_id_stage_t fetch_o;
  logic [2:0]   count_o;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .flush_i        (flush_i),
    .fetch_i        (fetch_i),
    .ready_o        (ready_o),
    .decode_ready_i (decode_ready_i),
    .fetch_o        (fetch_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic        dready;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_count;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // Side fields derive from the PC so forwarding of ex/bpred is checked too.
  function automatic if_id_stage_t make_pkt(input logic [31:0] pc, input logic v);
    if_id_stage_t p;
    p = '0;
    p.pc_inst         = pc;
    p.inst            = pc ^ 32'h0013_0013;
    p.valid           = v;
    p.ex.valid        = pc[4];
    p.ex.cause        = pc[5:2];
    p.ex.origin       = ~pc;
    p.bpred.is_branch = pc[3];
    p.bpred.decision  = pc[2];
    p.bpred.pred_addr = pc + 32'h40;
    return p;
  endfunction

  function automatic void add_vec(input logic fl, input logic v, input logic [31:0] pc,
                                  input logic dr, input logic er, input logic ev,
                                  input logic [31:0] epc, input logic [2:0] ec,
                                  input string nm);
    vec_t t;
    t.flush = fl; t.valid = v; t.pc = pc; t.dready = dr;
    t.e_ready = er; t.e_valid = ev; t.e_pc = epc; t.e_count = ec; t.name = nm;
    vecs.push_back(t);
  endfunction

  task automatic check_bit(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_output(input string nm, input logic er, input logic ev,
                              input logic [31:0] epc, input logic [2:0] ec);
    if_id_stage_t exp_pkt;
    check_bit({nm, ".ready"}, ready_o, er);
    check_bit({nm, ".valid"}, fetch_o.valid, ev);
    total++;
    if (count_o !== ec) begin
      bad++;
      $display("[TB] FAIL %s.count: got %0d expected %0d", nm, count_o, ec);
    end
    if (ev) begin
      exp_pkt = make_pkt(epc, 1'b1);
      total++;
      if (fetch_o !== exp_pkt) begin
        bad++;
        $display("[TB] FAIL %s.pkt: got %h expected %h", nm, fetch_o, exp_pkt);
      end
    end
  endtask

  task automatic apply_stimulus(input logic fl, input logic v, input logic [31:0] pc,
                                input logic dr);
    @(negedge clk_i);
    flush_i        = fl;
    fetch_i        = make_pkt(pc, v);
    decode_ready_i = dr;
    #1;
  endtask

  initial begin
    // fill, then full refusal (including refusal with a concurrent pop), then drain
    add_vec(0, 0, 32'h0,   0, 1, 0, 32'h0,   3'd0, "idle");
    add_vec(0, 1, 32'h100, 0, 1, 0, 32'h0,   3'd0, "fill0");
    add_vec(0, 1, 32'h104, 0, 1, 1, 32'h100, 3'd1, "fill1");
    add_vec(0, 1, 32'h108, 0, 1, 1, 32'h100, 3'd2, "fill2");
    add_vec(0, 1, 32'h10C, 0, 1, 1, 32'h100, 3'd3, "fill3");
    add_vec(0, 1, 32'h110, 0, 0, 1, 32'h100, 3'd4, "full_push");
    add_vec(0, 0, 32'h0,   0, 0, 1, 32'h100, 3'd4, "full_hold");
    add_vec(0, 1, 32'h110, 1, 0, 1, 32'h100, 3'd4, "full_push_pop");
    add_vec(0, 0, 32'h0,   1, 1, 1, 32'h104, 3'd3, "drain1");
    add_vec(0, 0, 32'h0,   1, 1, 1, 32'h108, 3'd2, "drain2");
    add_vec(0, 0, 32'h0,   1, 1, 1, 32'h10C, 3'd1, "drain3");
    add_vec(0, 0, 32'h0,   0, 1, 0, 32'h0,   3'd0, "drained");
    // streaming across the pointer wrap
    add_vec(0, 1, 32'h200, 1, 1, 0, 32'h0,   3'd0, "stream0");
    for (int i = 1; i < 10; i++)
      add_vec(0, 1, 32'h200 + 32'(4 * i), 1, 1, 1, 32'h200 + 32'(4 * (i - 1)), 3'd1,
              $sformatf("stream%0d", i));
    add_vec(0, 0, 32'h0,   1, 1, 1, 32'h224, 3'd1, "stream_tail");
    add_vec(0, 0, 32'h0,   0, 1, 0, 32'h0,   3'd0, "stream_empty");
    // flush with concurrent push and pop
    add_vec(0, 1, 32'h280, 0, 1, 0, 32'h0,   3'd0, "pre_flush0");
    add_vec(0, 1, 32'h284, 0, 1, 1, 32'h280, 3'd1, "pre_flush1");
    add_vec(0, 1, 32'h288, 0, 1, 1, 32'h280, 3'd2, "pre_flush2");
    add_vec(1, 1, 32'h300, 1, 1, 0, 32'h0,   3'd3, "flush");
    add_vec(0, 0, 32'h0,   1, 1, 0, 32'h0,   3'd0, "post_flush0");
    add_vec(0, 0, 32'h0,   1, 1, 0, 32'h0,   3'd0, "post_flush1");

    rstn_i = 1'b0;
    #1;
    check_output("in_reset", 1'b1, 1'b0, 32'h0, 3'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    check_output("reset_release", 1'b1, 1'b0, 32'h0, 3'd0);

    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].flush, vecs[k].valid, vecs[k].pc, vecs[k].dready);
      check_output(vecs[k].name, vecs[k].e_ready, vecs[k].e_valid, vecs[k].e_pc,
                   vecs[k].e_count);
    end

    // asynchronous reset while two entries are held
    apply_stimulus(0, 1, 32'h400, 0);
    apply_stimulus(0, 1, 32'h404, 0);
    check_output("mid_hold1", 1'b1, 1'b1, 32'h400, 3'd1);
    apply_stimulus(0, 0, 32'h0, 1);
    check_output("mid_hold2", 1'b1, 1'b1, 32'h400, 3'd2);
    #1 rstn_i = 1'b0;
    #1;
    check_output("mid_reset", 1'b1, 1'b0, 32'h0, 3'd0);
    #1 rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_output("after_mid_reset", 1'b1, 1'b0, 32'h0, 3'd0);
    apply_stimulus(0, 1, 32'h500, 0);
    apply_stimulus(0, 0, 32'h0, 0);
    check_output("restart", 1'b1, 1'b1, 32'h500, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and the decode stage. It buffers `if_id_stage_t` packets produced by fetch so that a decode stall does not immediately stall fetch or drop an icache response. It presents packets to decode in order and discards all entries on a pipeline redirect (flush).

## Interface

**Parameters**
- `DEPTH`, default 4: number of entries; must be a power of two, ≥ 2.

**Ports**
- `clk_i`  in  1: clock, all state on rising edge.
- `rstn_i`  in  1: reset; asynchronous, active-low.
- `flush_i`  in  1: redirect (commit / mispredict); discard all entries.
- `fetch_i`  in  `if_id_stage_t`: packet from fetch; `fetch_i.valid` is the push request.
- `ready_o`  out  1: queue can accept a push this cycle; fetch stalls when low.
- `decode_ready_i`  in  1: decode consumes the head this cycle.
- `fetch_o`  out  `if_id_stage_t`: head packet to decode; `fetch_o.valid` marks it valid.
- `count_o`  out  `$clog2(DEPTH)+1`: current occupancy, 0..DEPTH.

## Operation

- Circular buffer of DEPTH entries.
  - Write and read pointers are `$clog2(DEPTH)+1` bits wide; the MSB is a wrap bit.
  - Empty: pointers are equal.
  - Full: pointer indices are equal and wrap bits differ.
- **Push** = `fetch_i.valid & ready_o & !flush_i`. It writes `fetch_i` at the write pointer, then the write pointer increments.
- **Pop** = `fetch_o.valid & decode_ready_i & !flush_i`. The read pointer increments.
- `ready_o = !full`. It does not depend on `decode_ready_i`, so there is no combinational path decode→fetch. When full, a push is refused even if a pop happens in the same cycle.
- `fetch_o` is the entry at the read pointer when non-empty. When empty it is all-zero, so `valid = 0`.
- `fetch_o.valid` is forced to 0 in any cycle where `flush_i = 1`.
- **Flush** has highest priority:
  - Next cycle: pointers = 0, count = 0.
  - A same-cycle push and pop are both ignored.
- **Simultaneous push and pop** when non-empty and non-full: count is unchanged and both pointers advance.
- **Wrap-around:** pointers increment modulo 2·DEPTH, so entry order is preserved across the wrap.
- `count_o` is registered and updates by +1 on push only, −1 on pop only, and 0 on both or neither.
- Exception and branch-prediction fields (`ex`, `bpred`) are stored and forwarded unchanged; the block does not interpret them.

## Timing

- **Reset values:** `ready_o = 1`, `fetch_o = '0` (`valid = 0`), `count_o = 0`, pointers = 0. Storage array is not reset.
- **Latency, macro off:** a packet pushed in cycle N is visible on `fetch_o` in cycle N+1.
- **Throughput:** 1 packet/cycle sustained when decode is always ready.
- **Full:** `ready_o` drops the cycle after the DEPTH-th outstanding push. It rises the cycle after the first pop from full.
- **Reset asserted mid-operation:** all state clears asynchronously and outputs take their reset values immediately.

## Configuration

- `FETCH_QUEUE_BYPASS_EN` defined:
  - When the queue is empty and `fetch_i.valid = 1` and `flush_i = 0`, `fetch_o` is driven combinationally from `fetch_i` (0-cycle latency).
  - If `decode_ready_i = 1` that cycle, the packet is consumed and not written (count stays 0).
  - Otherwise the packet is written normally.
- Not defined: no bypass; minimum latency is 1 cycle and `fetch_o` is purely registered-state driven.

## Structure

- The following go in `drac_pkg`:
  - `FETCH_QUEUE_DEPTH` constant (default 4).
  - `fq_ptr_t` typedef (`$clog2(FETCH_QUEUE_DEPTH)+1` bits).
  - Reuse of the existing `if_id_stage_t`.
- No sub-module. Storage, pointers and count are a single module; the logic is too small to split.

## Test plan

- **Reset / idle:** hold `rstn_i = 0` for 3 cycles, then release → `ready_o = 1`, `fetch_o.valid = 0`, `count_o = 0`.
- **Fill:** DEPTH = 4, `decode_ready_i = 0`, push PCs 0x100, 0x104, 0x108, 0x10C → `count_o = 4`, `ready_o = 0`, a 5th push (0x110) is ignored, and the head stays 0x100.
- **Drain in order:** continuing from the fill, `decode_ready_i = 1` for 4 cycles → `fetch_o.pc_inst` is 0x100, 0x104, 0x108, 0x10C, then `valid = 0` and `count_o = 0`.
- **Streaming and wrap-around:**
  - Push and pop every cycle for 10 packets starting at 0x200 → `count_o` holds at 1 (macro off) or 0 (macro on).
  - Output sequence is 0x200..0x224, with no loss or duplication across the pointer wrap.
- **Flush with concurrent traffic:** 3 entries held, `flush_i = 1` together with a push of 0x300 and `decode_ready_i = 1` → next cycle `count_o = 0` and `fetch_o.valid = 0`, and 0x300 is never output.
- **Reset mid-operation:** 2 entries held, `rstn_i` pulsed low between clock edges → outputs return to reset values at once, with no pop recorded.
